// File: rtl/order_risk_gate_if.sv
// order_risk_gate_if: valid/ready order bus from the risk gate to the
// order encoder.
//   master (risk gate): drives ord_valid/ord_side/ord_price/ord_qty/ord_inst/ord_id
//                       and samples ord_ready
//   slave  (encoder)  : samples the order fields and drives ord_ready
`ifndef PRICE_W
`define PRICE_W 32
`endif
`ifndef SIZE_W
`define SIZE_W 16
`endif
`ifndef INST_ID_W
`define INST_ID_W 8
`endif

interface order_risk_gate_if #(
    parameter int ORDER_ID_W = 16
);
    logic                   ord_valid;
    logic                   ord_ready;
    logic                   ord_side;
    logic [`PRICE_W-1:0]    ord_price;
    logic [`SIZE_W-1:0]     ord_qty;
    logic [`INST_ID_W-1:0]  ord_inst;
    logic [ORDER_ID_W-1:0]  ord_id;

    modport master (
        output ord_valid, ord_side, ord_price, ord_qty, ord_inst, ord_id,
        input  ord_ready
    );

    modport slave (
        input  ord_valid, ord_side, ord_price, ord_qty, ord_inst, ord_id,
        output ord_ready
    );
endinterface

// File: rtl/order_risk_gate.sv
// order_risk_gate: pre-trade risk gate and single-entry order register.
// A strategy signal is checked (kill switch, instrument, busy slot, qty,
// price band, net position, token-bucket rate) in the cycle it arrives; an
// accepted signal is presented as a held order on the next cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable, pos_clear     kill switch / synchronous clear of all positions
//   sig_*                 one-cycle strategy signal
//   max_order_qty, price_lo, price_hi, pos_limit   risk limits
//   ord (master)          order bus toward the encoder
//   accept_cnt, reject_cnt, last_reject            saturating stats, last reason
`ifndef PRICE_W
`define PRICE_W 32
`endif
`ifndef SIZE_W
`define SIZE_W 16
`endif
`ifndef INST_ID_W
`define INST_ID_W 8
`endif

module order_risk_gate #(
    parameter int NUM_INST      = 4,
    parameter int POS_W         = 24,
    parameter int TOKEN_MAX     = 8,
    parameter int REFILL_CYCLES = 1000,
    parameter int ORDER_ID_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  pos_clear,
    input  logic                  sig_valid,
    input  logic                  sig_side,
    input  logic [`PRICE_W-1:0]   sig_price,
    input  logic [`SIZE_W-1:0]    sig_qty,
    input  logic [`INST_ID_W-1:0] sig_inst,
    input  logic [`SIZE_W-1:0]    max_order_qty,
    input  logic [`PRICE_W-1:0]   price_lo,
    input  logic [`PRICE_W-1:0]   price_hi,
    input  logic [POS_W-2:0]      pos_limit,
    order_risk_gate_if.master     ord,
    output logic [31:0]           accept_cnt,
    output logic [31:0]           reject_cnt,
    output logic [2:0]            last_reject
);
    localparam int INST_IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
    localparam int TOK_W      = $clog2(TOKEN_MAX + 1);
    localparam int REF_W      = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic [TOK_W-1:0] TOK_FULL = TOK_W'(TOKEN_MAX);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFILL_CYCLES - 1);

    typedef enum logic [2:0] {
        RSN_NONE     = 3'd0,
        RSN_DISABLED = 3'd1,
        RSN_BAD_INST = 3'd2,
        RSN_BUSY     = 3'd3,
        RSN_QTY      = 3'd4,
        RSN_PRICE    = 3'd5,
        RSN_POSITION = 3'd6,
        RSN_RATE     = 3'd7
    } reason_e;

    logic signed [POS_W-1:0] pos_q [NUM_INST];
    logic signed [POS_W-1:0] pos_d [NUM_INST];
    logic [ORDER_ID_W-1:0]   next_id_q, next_id_d;
    logic [TOK_W-1:0]        tokens_q, tokens_d;
    logic [REF_W-1:0]        refill_cnt_q, refill_cnt_d;
    logic                    ord_valid_q, ord_valid_d;
    logic                    ord_side_q, ord_side_d;
    logic [`PRICE_W-1:0]     ord_price_q, ord_price_d;
    logic [`SIZE_W-1:0]      ord_qty_q, ord_qty_d;
    logic [`INST_ID_W-1:0]   ord_inst_q, ord_inst_d;
    logic [ORDER_ID_W-1:0]   ord_id_q, ord_id_d;
    logic [31:0]             accept_cnt_q, accept_cnt_d;
    logic [31:0]             reject_cnt_q, reject_cnt_d;
    logic [2:0]              last_reject_q, last_reject_d;

    logic [INST_IDX_W-1:0]   inst_idx_s;
    logic signed [POS_W:0]   pos_ext_s, qty_ext_s, proj_s, lim_s;
    logic                    busy_s, refill_wrap_s, accept_s, reject_s;
    reason_e                 reason_s;

    // Risk checks: first failing check in priority order sets the reason.
    always_comb begin
        busy_s     = ord_valid_q && !ord.ord_ready;
        inst_idx_s = sig_inst[INST_IDX_W-1:0];
        pos_ext_s  = {pos_q[inst_idx_s][POS_W-1], pos_q[inst_idx_s]};
        qty_ext_s  = $signed({{(POS_W + 1 - `SIZE_W){1'b0}}, sig_qty});
        // Projection is one bit wider than the position so it cannot wrap.
        proj_s     = sig_side ? (pos_ext_s + qty_ext_s) : (pos_ext_s - qty_ext_s);
        lim_s      = $signed({2'b00, pos_limit});
        reason_s   = RSN_NONE;
        if (!enable || pos_clear) begin
            reason_s = RSN_DISABLED;
        end else if (32'(sig_inst) >= 32'(NUM_INST)) begin
            reason_s = RSN_BAD_INST;
        end else if (busy_s) begin
            reason_s = RSN_BUSY;
        end else if ((sig_qty == {`SIZE_W{1'b0}}) || (sig_qty > max_order_qty)) begin
            reason_s = RSN_QTY;
        end else if ((sig_price < price_lo) || (sig_price > price_hi)) begin
            reason_s = RSN_PRICE;
        end else if ((proj_s > lim_s) || (proj_s < -lim_s)) begin
            reason_s = RSN_POSITION;
        end else if (tokens_q == {TOK_W{1'b0}}) begin
            reason_s = RSN_RATE;
        end else begin
            reason_s = RSN_NONE;
        end
        accept_s = sig_valid && (reason_s == RSN_NONE);
        reject_s = sig_valid && (reason_s != RSN_NONE);
    end

    // Next-state: positions, order slot, ID, token bucket and statistics.
    always_comb begin
        for (int i = 0; i < NUM_INST; i++) begin
            if (pos_clear) begin
                pos_d[i] = {POS_W{1'b0}};
            end else if (accept_s && (inst_idx_s == INST_IDX_W'(i))) begin
                pos_d[i] = proj_s[POS_W-1:0];
            end else begin
                pos_d[i] = pos_q[i];
            end
        end

        ord_valid_d = ord_valid_q;
        ord_side_d  = ord_side_q;
        ord_price_d = ord_price_q;
        ord_qty_d   = ord_qty_q;
        ord_inst_d  = ord_inst_q;
        ord_id_d    = ord_id_q;
        next_id_d   = next_id_q;
        // Accept is never granted while busy, so loading here cannot
        // overwrite an order still waiting for ord_ready.
        if (accept_s) begin
            ord_valid_d = 1'b1;
            ord_side_d  = sig_side;
            ord_price_d = sig_price;
            ord_qty_d   = sig_qty;
            ord_inst_d  = sig_inst;
            ord_id_d    = next_id_q;
            next_id_d   = next_id_q + {{(ORDER_ID_W-1){1'b0}}, 1'b1};
        end else if (ord_valid_q && ord.ord_ready) begin
            ord_valid_d = 1'b0;
        end else begin
            ord_valid_d = ord_valid_q;
        end

        refill_wrap_s = (refill_cnt_q == REF_LAST);
        refill_cnt_d  = refill_wrap_s ? {REF_W{1'b0}} : (refill_cnt_q + {{(REF_W-1){1'b0}}, 1'b1});
        case ({refill_wrap_s, accept_s})
            2'b10:   tokens_d = (tokens_q < TOK_FULL) ? (tokens_q + {{(TOK_W-1){1'b0}}, 1'b1}) : tokens_q;
            2'b01:   tokens_d = tokens_q - {{(TOK_W-1){1'b0}}, 1'b1};
            default: tokens_d = tokens_q;
        endcase

        accept_cnt_d  = (accept_s && (accept_cnt_q != 32'hFFFF_FFFF)) ? (accept_cnt_q + 32'd1) : accept_cnt_q;
        reject_cnt_d  = (reject_s && (reject_cnt_q != 32'hFFFF_FFFF)) ? (reject_cnt_q + 32'd1) : reject_cnt_q;
        last_reject_d = reject_s ? reason_s : last_reject_q;
    end

    // State registers; reset refills the bucket and drops any held order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INST; i++) begin
                pos_q[i] <= {POS_W{1'b0}};
            end
            next_id_q     <= {ORDER_ID_W{1'b0}};
            tokens_q      <= TOK_FULL;
            refill_cnt_q  <= {REF_W{1'b0}};
            ord_valid_q   <= 1'b0;
            ord_side_q    <= 1'b0;
            ord_price_q   <= {`PRICE_W{1'b0}};
            ord_qty_q     <= {`SIZE_W{1'b0}};
            ord_inst_q    <= {`INST_ID_W{1'b0}};
            ord_id_q      <= {ORDER_ID_W{1'b0}};
            accept_cnt_q  <= 32'd0;
            reject_cnt_q  <= 32'd0;
            last_reject_q <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_INST; i++) begin
                pos_q[i] <= pos_d[i];
            end
            next_id_q     <= next_id_d;
            tokens_q      <= tokens_d;
            refill_cnt_q  <= refill_cnt_d;
            ord_valid_q   <= ord_valid_d;
            ord_side_q    <= ord_side_d;
            ord_price_q   <= ord_price_d;
            ord_qty_q     <= ord_qty_d;
            ord_inst_q    <= ord_inst_d;
            ord_id_q      <= ord_id_d;
            accept_cnt_q  <= accept_cnt_d;
            reject_cnt_q  <= reject_cnt_d;
            last_reject_q <= last_reject_d;
        end
    end

    assign ord.ord_valid = ord_valid_q;
    assign ord.ord_side  = ord_side_q;
    assign ord.ord_price = ord_price_q;
    assign ord.ord_qty   = ord_qty_q;
    assign ord.ord_inst  = ord_inst_q;
    assign ord.ord_id    = ord_id_q;
    assign accept_cnt    = accept_cnt_q;
    assign reject_cnt    = reject_cnt_q;
    assign last_reject   = last_reject_q;
endmodule

// File: tb/tb_order_risk_gate.sv
// tb_order_risk_gate: directed, table-driven check of order_risk_gate.
`ifndef PRICE_W
`define PRICE_W 32
`endif
`ifndef SIZE_W
`define SIZE_W 16
`endif
`ifndef INST_ID_W
`define INST_ID_W 8
`endif

module tb_order_risk_gate;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        pos_clear = 1'b0;
    logic        sig_valid = 1'b0;
    logic        sig_side = 1'b0;
    logic [31:0] sig_price = 32'd0;
    logic [15:0] sig_qty = 16'd0;
    logic [7:0]  sig_inst = 8'd0;
    logic [15:0] max_order_qty = 16'd50;
    logic [31:0] price_lo = 32'd1000;
    logic [31:0] price_hi = 32'd2000;
    logic [22:0] pos_limit = 23'd100;
    logic [31:0] accept_cnt, reject_cnt;
    logic [2:0]  last_reject;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc    = 0;
    int m_rej    = 0;
    int cyc      = 0;

    order_risk_gate_if #(.ORDER_ID_W(16)) ord_bus ();

    order_risk_gate dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pos_clear(pos_clear),
        .sig_valid(sig_valid), .sig_side(sig_side), .sig_price(sig_price),
        .sig_qty(sig_qty), .sig_inst(sig_inst), .max_order_qty(max_order_qty),
        .price_lo(price_lo), .price_hi(price_hi), .pos_limit(pos_limit),
        .ord(ord_bus.master), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt),
        .last_reject(last_reject)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic        en;
        logic        clr;
        logic        side;
        logic [31:0] px;
        logic [15:0] qty;
        logic [7:0]  inst;
        logic [2:0]  code;   // 0 = accepted
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sig_valid = 1'b0; enable = 1'b1; pos_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_acc = 0; m_rej = 0;
    endtask

    // Present one signal for one clock; returns at posedge+1 of its decision edge.
    task automatic send(input logic en, input logic clr, input logic side,
                        input logic [31:0] px, input logic [15:0] qty, input logic [7:0] inst);
        enable = en; pos_clear = clr; sig_valid = 1'b1;
        sig_side = side; sig_price = px; sig_qty = qty; sig_inst = inst;
        @(posedge clk);
        #1;
        sig_valid = 1'b0; enable = 1'b1; pos_clear = 1'b0;
    endtask

    task automatic chk_acc(input string name, input int id);
        m_acc++;
        chk({name, ".valid"}, 64'(ord_bus.ord_valid), 64'd1);
        chk({name, ".id"}, 64'(ord_bus.ord_id), 64'(id));
        chk({name, ".acc_cnt"}, 64'(accept_cnt), 64'(m_acc));
    endtask

    task automatic chk_rej(input string name, input logic [2:0] code);
        m_rej++;
        chk({name, ".code"}, 64'(last_reject), 64'(code));
        chk({name, ".rej_cnt"}, 64'(reject_cnt), 64'(m_rej));
        chk({name, ".acc_cnt"}, 64'(accept_cnt), 64'(m_acc));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_id;
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'd1000, 16'd50, 8'd0, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'd2000, 16'd50, 8'd0, 3'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'd999,  16'd10, 8'd0, 3'd5};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'd2001, 16'd10, 8'd0, 3'd5};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd0,  8'd0, 3'd4};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd51, 8'd0, 3'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd4, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd1500, 16'd0,  8'd4, 3'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'd1500, 16'd10, 8'd3, 3'd1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'd1500, 16'd50, 8'd3, 3'd0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'd1500, 16'd1,  8'd3, 3'd6};

        ord_bus.ord_ready = 1'b1;

        // Reset values and first order latency.
        do_reset();
        chk("rst.valid", 64'(ord_bus.ord_valid), 64'd0);
        chk("rst.acc", 64'(accept_cnt), 64'd0);
        chk("rst.rej", 64'(reject_cnt), 64'd0);
        chk("rst.last", 64'(last_reject), 64'd0);
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd30, 8'd1);
        chk_acc("first", 0);
        chk("first.side", 64'(ord_bus.ord_side), 64'd1);
        chk("first.qty", 64'(ord_bus.ord_qty), 64'd30);
        chk("first.inst", 64'(ord_bus.ord_inst), 64'd1);
        chk("first.price", 64'(ord_bus.ord_price), 64'd1500);

        // Position limit with back-to-back signals on one instrument.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd30, 8'd1);
            chk_acc("pos.buy", i);
        end
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd30, 8'd1);
        chk_rej("pos.over", 3'd6);
        chk("pos.over.valid", 64'(ord_bus.ord_valid), 64'd0);
        send(1'b1, 1'b0, 1'b0, 32'd1500, 16'd30, 8'd1);
        chk_acc("pos.sell", 3);
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd30, 8'd1);
        chk_acc("pos.rebuy", 4);
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd1);
        chk_acc("pos.exact", 5);
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd1, 8'd1);
        chk_rej("pos.plus1", 3'd6);

        // Backpressure: held order stays stable, second signal is BUSY.
        do_reset();
        ord_bus.ord_ready = 1'b0;
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd2);
        chk_acc("bp.first", 0);
        send(1'b1, 1'b0, 1'b0, 32'd1600, 16'd20, 8'd2);
        chk_rej("bp.busy", 3'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold.valid", 64'(ord_bus.ord_valid), 64'd1);
            chk("bp.hold.qty", 64'(ord_bus.ord_qty), 64'd10);
            chk("bp.hold.px", 64'(ord_bus.ord_price), 64'd1500);
            chk("bp.hold.id", 64'(ord_bus.ord_id), 64'd0);
            @(posedge clk); #1;
        end
        ord_bus.ord_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.drain", 64'(ord_bus.ord_valid), 64'd0);

        // Table: band/qty/inst/priority/pos_clear/negative limit.
        do_reset();
        exp_id = 0;
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].en, vecs[i].clr, vecs[i].side, vecs[i].px, vecs[i].qty, vecs[i].inst);
            if (vecs[i].code == 3'd0) begin
                chk_acc($sformatf("vec%0d", i), exp_id);
                chk($sformatf("vec%0d.qty", i), 64'(ord_bus.ord_qty), 64'(vecs[i].qty));
                chk($sformatf("vec%0d.side", i), 64'(ord_bus.ord_side), 64'(vecs[i].side));
                exp_id++;
            end else begin
                chk_rej($sformatf("vec%0d", i), vecs[i].code);
                chk($sformatf("vec%0d.valid", i), 64'(ord_bus.ord_valid), 64'd0);
            end
        end

        // Token bucket: burst of 8, refill at 1000 cycles.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(1'b1, 1'b0, ((i % 2) == 0), 32'd1500, 16'd10, 8'd0);
            if (i < 8) chk_acc("rate.burst", i);
            else       chk_rej("rate.empty", 3'd7);
        end
        while (cyc < 980) @(posedge clk);
        #1;
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd0);
        chk_rej("rate.prewrap", 3'd7);
        while (cyc < 1010) @(posedge clk);
        #1;
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd0);
        chk_acc("rate.refill", 8);
        send(1'b1, 1'b0, 1'b0, 32'd1500, 16'd10, 8'd0);
        chk_rej("rate.again", 3'd7);

        // Async reset while an order is held.
        do_reset();
        ord_bus.ord_ready = 1'b0;
        send(1'b1, 1'b0, 1'b1, 32'd1500, 16'd10, 8'd1);
        chk_acc("ar.held", 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", 64'(ord_bus.ord_valid), 64'd0);
        chk("ar.acc", 64'(accept_cnt), 64'd0);
        chk("ar.rej", 64'(reject_cnt), 64'd0);
        m_acc = 0; m_rej = 0;
        #3 rst_n = 1'b1;
        ord_bus.ord_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            send(1'b1, 1'b0, ((i % 2) == 0), 32'd1500, 16'd10, 8'd1);
            if (i < 8) chk_acc("ar.burst", i);
            else       chk_rej("ar.empty", 3'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
